// File: rtl/ofs_plat_avalon_mem_sink_emul_pkg.sv
// Shared types for the Avalon-MM local-memory sink emulator.
// The default geometry below sets the read-command field widths.
package ofs_plat_avalon_mem_sink_emul_pkg;

  localparam int unsigned RAM_ADDR_BITS_DFLT   = 10;
  localparam int unsigned BURST_CNT_WIDTH_DFLT = 7;

  typedef struct packed {
    logic [RAM_ADDR_BITS_DFLT-1:0]   addr;
    logic [BURST_CNT_WIDTH_DFLT-1:0] len;
  } rd_cmd_t;

  typedef enum logic {
    WR_IDLE  = 1'b0,
    WR_BURST = 1'b1
  } wr_state_t;

  // A zero burstcount is treated as a single beat.
  function automatic rd_cmd_t mk_rd_cmd(input logic [RAM_ADDR_BITS_DFLT-1:0]   addr,
                                        input logic [BURST_CNT_WIDTH_DFLT-1:0] len);
    rd_cmd_t c;
    c.addr = addr;
    c.len  = (len == '0) ? BURST_CNT_WIDTH_DFLT'(1) : len;
    return c;
  endfunction

endpackage

// File: rtl/ofs_plat_avalon_mem_sink_emul_rd_engine.sv
// Read path: command FIFO, burst address generator and fixed-latency
// valid/data pipeline. The RAM read register counts as the first stage.
module ofs_plat_avalon_mem_sink_emul_rd_engine
  import ofs_plat_avalon_mem_sink_emul_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 512,
  parameter int unsigned READ_LATENCY   = 4,
  parameter int unsigned CMD_FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          push,
  input  rd_cmd_t                       push_cmd,
  output logic                          cmd_full,
  output logic                          rd_busy,
  output logic                          ram_rd_en,
  output logic [RAM_ADDR_BITS_DFLT-1:0] ram_rd_addr,
  input  logic [DATA_WIDTH-1:0]         ram_rdata,
  output logic [DATA_WIDTH-1:0]         readdata,
  output logic                          readdatavalid
);

  localparam int unsigned PTR_W = $clog2(CMD_FIFO_DEPTH);
  localparam int unsigned AW    = RAM_ADDR_BITS_DFLT;
  localparam int unsigned LW    = BURST_CNT_WIDTH_DFLT;

  rd_cmd_t          fifo_q [CMD_FIFO_DEPTH];
  logic [PTR_W:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic             fifo_empty, pop;
  rd_cmd_t          head;
  logic             eng_act_q, eng_act_d;
  logic [AW-1:0]    eng_addr_q, eng_addr_d;
  logic [LW-1:0]    eng_rem_q, eng_rem_d;
  logic [READ_LATENCY-1:0] vld_q, vld_d;

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign cmd_full   = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                      (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign head       = fifo_q[rd_ptr_q[PTR_W-1:0]];
  assign rd_busy    = ~fifo_empty | eng_act_q | (|vld_q);
  assign readdatavalid = vld_q[READ_LATENCY-1];

  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q[PTR_W-1:0]] <= push_cmd;
  end

  // Idle engine issues straight from the FIFO head; an active engine
  // preloads the next command on its last beat so bursts run back to back.
  always_comb begin
    pop         = 1'b0;
    ram_rd_en   = 1'b0;
    ram_rd_addr = eng_addr_q;
    eng_act_d   = eng_act_q;
    eng_addr_d  = eng_addr_q;
    eng_rem_d   = eng_rem_q;
    if (eng_act_q) begin
      ram_rd_en  = 1'b1;
      eng_addr_d = eng_addr_q + 1'b1;
      eng_rem_d  = eng_rem_q - 1'b1;
      if (eng_rem_q == LW'(1)) begin
        eng_act_d = ~fifo_empty;
        pop       = ~fifo_empty;
        if (!fifo_empty) begin
          eng_addr_d = head.addr;
          eng_rem_d  = head.len;
        end
      end
    end else if (!fifo_empty) begin
      pop         = 1'b1;
      ram_rd_en   = 1'b1;
      ram_rd_addr = head.addr;
      eng_addr_d  = head.addr + 1'b1;
      eng_rem_d   = head.len - 1'b1;
      eng_act_d   = (head.len != LW'(1));
    end
    wr_ptr_d = wr_ptr_q + (PTR_W+1)'(push);
    rd_ptr_d = rd_ptr_q + (PTR_W+1)'(pop);
    vld_d    = vld_q << 1;
    vld_d[0] = ram_rd_en;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      eng_act_q  <= 1'b0;
      eng_addr_q <= '0;
      eng_rem_q  <= '0;
      vld_q      <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      eng_act_q  <= eng_act_d;
      eng_addr_q <= eng_addr_d;
      eng_rem_q  <= eng_rem_d;
      vld_q      <= vld_d;
    end
  end

  if (READ_LATENCY == 1) begin : g_lat1
    assign readdata = ram_rdata;
  end else begin : g_latn
    logic [DATA_WIDTH-1:0] dat_q [READ_LATENCY-1];
    always_ff @(posedge clk) begin
      if (reset) begin
        for (int i = 0; i < int'(READ_LATENCY) - 1; i++) dat_q[i] <= '0;
      end else begin
        dat_q[0] <= ram_rdata;
        for (int i = 1; i < int'(READ_LATENCY) - 1; i++) dat_q[i] <= dat_q[i-1];
      end
    end
    assign readdata = dat_q[READ_LATENCY-2];
  end

endmodule

// File: rtl/ofs_plat_avalon_mem_sink_emul.sv
// Avalon-MM sink emulating a local-memory bank: byte-masked burst writes
// into an internal RAM, in-order burst reads after a fixed latency.
module ofs_plat_avalon_mem_sink_emul
  import ofs_plat_avalon_mem_sink_emul_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH      = 27,
  parameter int unsigned DATA_WIDTH      = 512,
  parameter int unsigned BURST_CNT_WIDTH = BURST_CNT_WIDTH_DFLT,
  parameter int unsigned RAM_ADDR_BITS   = RAM_ADDR_BITS_DFLT,
  parameter int unsigned READ_LATENCY    = 4,
  parameter int unsigned CMD_FIFO_DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  output logic                       waitrequest,
  input  logic [ADDR_WIDTH-1:0]      address,
  input  logic                       read,
  input  logic                       write,
  input  logic [BURST_CNT_WIDTH-1:0] burstcount,
  input  logic [DATA_WIDTH-1:0]      writedata,
  input  logic [DATA_WIDTH/8-1:0]    byteenable,
  output logic [DATA_WIDTH-1:0]      readdata,
  output logic                       readdatavalid
);

  localparam int unsigned BE_WIDTH  = DATA_WIDTH / 8;
  localparam int unsigned RAM_DEPTH = 1 << RAM_ADDR_BITS;

  logic                       reset_q;
  wr_state_t                  wr_state_q, wr_state_d;
  logic [RAM_ADDR_BITS-1:0]   wr_addr_q, wr_addr_d;
  logic [BURST_CNT_WIDTH-1:0] wr_rem_q, wr_rem_d;
  logic [BURST_CNT_WIDTH-1:0] len_eff;
  logic                       wr_in_burst, wr_accept, rd_accept;
  logic                       ram_wr_en;
  logic [RAM_ADDR_BITS-1:0]   ram_wr_addr;
  logic                       cmd_full, rd_busy, ram_rd_en;
  logic [RAM_ADDR_BITS_DFLT-1:0] ram_rd_addr;
  logic [DATA_WIDTH-1:0]      ram [RAM_DEPTH];
  logic [DATA_WIDTH-1:0]      ram_rdata_q;
  rd_cmd_t                    rd_cmd;
  logic                       unused_addr_hi;

  assign unused_addr_hi = ^address[ADDR_WIDTH-1:RAM_ADDR_BITS];

  // Writes stall behind outstanding reads so reads never see later writes.
  assign wr_in_burst = (wr_state_q == WR_BURST);
  assign waitrequest = reset | reset_q | (read & cmd_full) |
                       (write & rd_busy & ~wr_in_burst);
  assign wr_accept   = write & ~waitrequest;
  assign rd_accept   = read & ~write & ~waitrequest & ~wr_in_burst;
  assign len_eff     = (burstcount == '0) ? BURST_CNT_WIDTH'(1) : burstcount;
  assign rd_cmd      = mk_rd_cmd(RAM_ADDR_BITS_DFLT'(address[RAM_ADDR_BITS-1:0]),
                                 BURST_CNT_WIDTH_DFLT'(len_eff));

  always_comb begin
    wr_state_d  = wr_state_q;
    wr_addr_d   = wr_addr_q;
    wr_rem_d    = wr_rem_q;
    ram_wr_en   = 1'b0;
    ram_wr_addr = wr_addr_q;
    case (wr_state_q)
      WR_IDLE: begin
        if (wr_accept) begin
          ram_wr_en   = 1'b1;
          ram_wr_addr = address[RAM_ADDR_BITS-1:0];
          wr_addr_d   = address[RAM_ADDR_BITS-1:0] + 1'b1;
          wr_rem_d    = len_eff - 1'b1;
          if (len_eff != BURST_CNT_WIDTH'(1)) wr_state_d = WR_BURST;
        end
      end
      WR_BURST: begin
        if (wr_accept) begin
          ram_wr_en = 1'b1;
          wr_addr_d = wr_addr_q + 1'b1;
          wr_rem_d  = wr_rem_q - 1'b1;
          if (wr_rem_q == BURST_CNT_WIDTH'(1)) wr_state_d = WR_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    reset_q <= reset;
    if (reset) begin
      wr_state_q <= WR_IDLE;
      wr_addr_q  <= '0;
      wr_rem_q   <= '0;
    end else begin
      wr_state_q <= wr_state_d;
      wr_addr_q  <= wr_addr_d;
      wr_rem_q   <= wr_rem_d;
    end
  end

  // RAM contents survive reset; only the read register is cleared.
  always_ff @(posedge clk) begin
    if (ram_wr_en) begin
      for (int b = 0; b < int'(BE_WIDTH); b++) begin
        if (byteenable[b]) ram[ram_wr_addr][b*8 +: 8] <= writedata[b*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset)          ram_rdata_q <= '0;
    else if (ram_rd_en) ram_rdata_q <= ram[RAM_ADDR_BITS'(ram_rd_addr)];
  end

  ofs_plat_avalon_mem_sink_emul_rd_engine #(
    .DATA_WIDTH     (DATA_WIDTH),
    .READ_LATENCY   (READ_LATENCY),
    .CMD_FIFO_DEPTH (CMD_FIFO_DEPTH)
  ) u_rd_engine (
    .clk           (clk),
    .reset         (reset),
    .push          (rd_accept),
    .push_cmd      (rd_cmd),
    .cmd_full      (cmd_full),
    .rd_busy       (rd_busy),
    .ram_rd_en     (ram_rd_en),
    .ram_rd_addr   (ram_rd_addr),
    .ram_rdata     (ram_rdata_q),
    .readdata      (readdata),
    .readdatavalid (readdatavalid)
  );

  a_burst_nonzero: assert property (@(posedge clk) disable iff (reset)
    ((read | write) && !waitrequest && !wr_in_burst) |-> (burstcount != '0));
  a_rd_wr_excl: assert property (@(posedge clk) disable iff (reset)
    !(read && write));
  a_no_rd_in_wr_burst: assert property (@(posedge clk) disable iff (reset)
    !(read && wr_in_burst));

endmodule

// File: tb/tb_ofs_plat_avalon_mem_sink_emul.sv
// Directed-with-random-data bench for the Avalon-MM sink emulator, checked
// against a line-array memory model and an expected-response queue.
module tb_ofs_plat_avalon_mem_sink_emul;

  localparam int unsigned AW    = 27;
  localparam int unsigned DW    = 512;
  localparam int unsigned BW    = 7;
  localparam int unsigned RB    = 10;
  localparam int unsigned LAT   = 4;
  localparam int unsigned FD    = 4;
  localparam int          DEPTH = 1 << RB;

  logic          clk = 1'b0;
  logic          reset;
  logic          waitrequest;
  logic [AW-1:0] address;
  logic          read, write;
  logic [BW-1:0] burstcount;
  logic [DW-1:0] writedata;
  logic [DW/8-1:0] byteenable;
  logic [DW-1:0] readdata;
  logic          readdatavalid;

  ofs_plat_avalon_mem_sink_emul #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_CNT_WIDTH(BW), .RAM_ADDR_BITS(RB),
    .READ_LATENCY(LAT), .CMD_FIFO_DEPTH(FD)
  ) dut (
    .clk(clk), .reset(reset), .waitrequest(waitrequest), .address(address),
    .read(read), .write(write), .burstcount(burstcount), .writedata(writedata),
    .byteenable(byteenable), .readdata(readdata), .readdatavalid(readdatavalid)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [DW-1:0] got_d[$];
  int unsigned   got_c[$];
  always @(negedge clk) begin
    if (readdatavalid) begin
      got_d.push_back(readdata);
      got_c.push_back(cyc);
    end
  end

  logic [DW-1:0]   mem [DEPTH];
  logic [DW-1:0]   exp_d[$];
  logic [DW-1:0]   wbuf_d [64];
  logic [DW/8-1:0] wbuf_be [64];
  int n_pass = 0;
  int n_total = 0;

  function automatic logic [DW-1:0] rand_line();
    logic [DW-1:0] v;
    for (int i = 0; i < int'(DW / 32); i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic int line_of(input logic [AW-1:0] a, input int i);
    return (int'(a[RB-1:0]) + i) % DEPTH;
  endfunction

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Called at a negedge with a beat driven; returns at the next negedge.
  task automatic wait_accept(input string tag, output int unsigned acc);
    int k = 0;
    #1;
    while (waitrequest !== 1'b0 && k < 300) begin
      @(negedge clk); #1; k++;
    end
    acc = cyc;
    if (waitrequest !== 1'b0) begin
      n_total++;
      $error("FAIL %s_accept_timeout: waitrequest %b expected 0", tag, waitrequest);
    end
    @(negedge clk);
  endtask

  task automatic write_burst(input logic [AW-1:0] a, input int n, output int unsigned acc0);
    int unsigned acc;
    acc0 = 0;
    for (int i = 0; i < n; i++) begin
      write = 1'b1; address = a; burstcount = BW'(n);
      writedata = wbuf_d[i]; byteenable = wbuf_be[i];
      wait_accept("wr", acc);
      if (i == 0) acc0 = acc;
      for (int b = 0; b < int'(DW / 8); b++)
        if (wbuf_be[i][b]) mem[line_of(a, i)][b*8 +: 8] = wbuf_d[i][b*8 +: 8];
    end
    write = 1'b0;
  endtask

  task automatic issue_read(input logic [AW-1:0] a, input int n, output int unsigned acc);
    read = 1'b1; address = a; burstcount = BW'(n);
    wait_accept("rd", acc);
    for (int i = 0; i < n; i++) exp_d.push_back(mem[line_of(a, i)]);
    read = 1'b0;
  endtask

  task automatic check_beats(input int n, input int unsigned first, input string tag);
    int k = 0;
    while (got_d.size() < n && k < 400) begin
      @(negedge clk); #1; k++;
    end
    if (got_d.size() < n) begin
      n_total++;
      $error("FAIL %s_timeout: observed %0d beats expected %0d", tag, got_d.size(), n);
    end
    for (int i = 0; i < n && got_d.size() > 0 && exp_d.size() > 0; i++) begin
      check({tag, "_data"}, got_d.pop_front(), exp_d.pop_front());
      check({tag, "_cyc"}, DW'(got_c.pop_front()), DW'(first + i));
    end
    repeat (LAT + 2) @(negedge clk);
    check({tag, "_extra"}, DW'(got_d.size()), DW'(0));
    got_d.delete(); got_c.delete(); exp_d.delete();
  endtask

  initial begin
    int unsigned acc, acc0, accw;
    int unsigned racc [6];
    logic [DW-1:0] v;
    int k;

    reset = 1'b1; read = 1'b0; write = 1'b0; address = '0; burstcount = BW'(1);
    writedata = '0; byteenable = '0;
    foreach (mem[i]) mem[i] = '0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_waitrequest", DW'(waitrequest), DW'(1));
    check("rst_readdatavalid", DW'(readdatavalid), DW'(0));
    check("rst_readdata", readdata, '0);
    reset = 1'b0; #1;
    check("rst_q_waitrequest", DW'(waitrequest), DW'(1));
    @(negedge clk); #1;
    check("post_rst_waitrequest", DW'(waitrequest), DW'(0));
    @(negedge clk);

    // Burst write 4 at 0x10 (low byte A0..A3), burst read back.
    for (int i = 0; i < 4; i++) begin
      v = rand_line(); v[7:0] = 8'hA0 + 8'(i);
      wbuf_d[i] = v; wbuf_be[i] = '1;
    end
    write_burst(AW'(32'h10), 4, acc);
    issue_read(AW'(32'h10), 4, acc);
    check_beats(4, acc + 1 + LAT, "t1");

    // Byte-enable merge on line 5.
    wbuf_d[0] = '1; wbuf_be[0] = '1;
    write_burst(AW'(5), 1, acc);
    wbuf_d[0] = '0; wbuf_be[0] = '0; wbuf_be[0][0] = 1'b1;
    write_burst(AW'(5), 1, acc);
    issue_read(AW'(5), 1, acc);
    v = '1; v[7:0] = 8'h00;
    void'(exp_d.pop_back());
    exp_d.push_back(v);
    check_beats(1, acc + 1 + LAT, "t2_be");

    // Prefill 0x40..0x4F and line 2 with random data.
    for (int i = 0; i < 16; i++) begin wbuf_d[i] = rand_line(); wbuf_be[i] = '1; end
    write_burst(AW'(32'h40), 16, acc);
    wbuf_d[0] = rand_line(); wbuf_be[0] = '1;
    write_burst(AW'(2), 1, acc);

    // FIFO fill: long burst keeps the engine busy while 4 short commands queue.
    issue_read(AW'(32'h40), 16, racc[0]);
    issue_read(AW'(32'h10), 2, racc[1]);
    issue_read(AW'(32'h12), 2, racc[2]);
    issue_read(AW'(32'h40), 2, racc[3]);
    issue_read(AW'(32'h44), 2, racc[4]);
    issue_read(AW'(32'h10), 2, racc[5]);
    for (int i = 1; i < 5; i++) check("t3_accept_cyc", DW'(racc[i]), DW'(racc[0] + i));
    check("t3_full_stall_cyc", DW'(racc[5]), DW'(racc[0] + 17));
    check_beats(26, racc[0] + 1 + LAT, "t3");

    // Write presented behind 3 outstanding reads.
    issue_read(AW'(32'h10), 1, acc0);
    issue_read(AW'(32'h11), 1, acc);
    issue_read(AW'(5), 1, acc);
    wbuf_d[0] = rand_line(); wbuf_be[0] = '1;
    write_burst(AW'(32'h10), 1, accw);
    check("t4_write_accept_cyc", DW'(accw), DW'(acc0 + 8));
    check_beats(3, acc0 + 1 + LAT, "t4_old");
    issue_read(AW'(32'h10), 1, acc);
    check_beats(1, acc + 1 + LAT, "t4_new");

    // Write burst wrapping past the top line; line 2 must stay untouched.
    for (int i = 0; i < 3; i++) begin wbuf_d[i] = rand_line(); wbuf_be[i] = '1; end
    write_burst(AW'(DEPTH - 1), 3, acc);
    issue_read(AW'(DEPTH - 1), 1, acc0);
    issue_read(AW'(DEPTH), 2, acc);
    issue_read(AW'(2), 1, acc);
    check_beats(4, acc0 + 1 + LAT, "t5_wrap");

    // Reset for one cycle after 3 beats of an 8-beat read.
    issue_read(AW'(32'h40), 8, acc);
    k = 0;
    while (got_d.size() < 3 && k < 100) begin
      @(negedge clk); #1; k++;
    end
    reset = 1'b1; #1;
    check("t6_wr_in_reset", DW'(waitrequest), DW'(1));
    @(negedge clk); #1;
    check("t6_wr_after_rst_edge", DW'(waitrequest), DW'(1));
    check("t6_rdv_after_rst_edge", DW'(readdatavalid), DW'(0));
    check("t6_rdata_after_rst_edge", readdata, '0);
    reset = 1'b0; #1;
    check("t6_wr_rst_q", DW'(waitrequest), DW'(1));
    @(negedge clk); #1;
    check("t6_wr_released", DW'(waitrequest), DW'(0));
    repeat (20) @(negedge clk);
    check("t6_beats_before_reset", DW'(got_d.size()), DW'(3));
    for (int i = 0; i < 3 && got_d.size() > 0 && exp_d.size() > 0; i++)
      check("t6_early_data", got_d.pop_front(), exp_d.pop_front());
    got_d.delete(); got_c.delete(); exp_d.delete();
    issue_read(AW'(32'h40), 8, acc);
    check_beats(8, acc + 1 + LAT, "t6_reread");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
